// File: rtl/ap_pkg.sv
// Shared encodings for the associative processor: command codes, CAM and
// bank selectors, operation direction/target, and FSM state constants.
package ap_pkg;

   // Command encodings
   localparam logic [2:0] CMD_OR   = 3'd0;
   localparam logic [2:0] CMD_XOR  = 3'd1;
   localparam logic [2:0] CMD_AND  = 3'd2;
   localparam logic [2:0] CMD_NOT  = 3'd3;
   localparam logic [2:0] CMD_ADD  = 3'd4;
   localparam logic [2:0] CMD_SUB  = 3'd5;
   localparam logic [2:0] CMD_MULT = 3'd6;
   localparam logic [2:0] CMD_SET  = 3'd7;

   // CAM selectors
   localparam logic [1:0] CAM_A    = 2'd0;
   localparam logic [1:0] CAM_B    = 2'd1;
   localparam logic [1:0] CAM_C    = 2'd2;
   localparam logic [1:0] CAM_NONE = 2'd3;

   // Bank (internal column) selectors
   localparam logic LEFT  = 1'b0;
   localparam logic RIGHT = 1'b1;

   // Operation direction and result target
   localparam logic DIR_VERT = 1'b0;
   localparam logic DIR_HORZ = 1'b1;
   localparam logic TGT_C    = 1'b0;
   localparam logic TGT_SRC  = 1'b1;

   // FSM states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/ap_cam.sv
// One CAM with two banks of CELL_QUANT words. Offers a word read/write port,
// a whole-bank clear, a whole-bank fill, and row-parallel bit-slice access.
// All bank-wide operations act on the bank given by 'bank'.
module ap_cam
   import ap_pkg::*;
#(
   parameter int WORD_SIZE  = 8,
   parameter int CELL_QUANT = 512,
   parameter int ADDR_W     = $clog2(CELL_QUANT),
   parameter int BIT_W      = $clog2(WORD_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bank,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [WORD_SIZE-1:0]  wdata,
   output logic [WORD_SIZE-1:0]  rdata,
   input  logic                  clr_en,
   input  logic                  fill_en,
   input  logic [WORD_SIZE-1:0]  fill_value,
   input  logic [BIT_W-1:0]      bit_idx,
   output logic [CELL_QUANT-1:0] slice_l,
   output logic [CELL_QUANT-1:0] slice_r,
   input  logic                  bs_we,
   input  logic [CELL_QUANT-1:0] bs_data
);

   logic [WORD_SIZE-1:0] mem [2][CELL_QUANT];

   // Storage update: clear, fill, bit-slice write and word write never
   // coincide in practice; the order here only fixes a priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < CELL_QUANT; r++)
               mem[b][r] <= '0;
      end else if (clr_en) begin
         for (int r = 0; r < CELL_QUANT; r++) mem[bank][r] <= '0;
      end else if (fill_en) begin
         for (int r = 0; r < CELL_QUANT; r++) mem[bank][r] <= fill_value;
      end else if (bs_we) begin
         for (int r = 0; r < CELL_QUANT; r++) mem[bank][r][bit_idx] <= bs_data[r];
      end else if (we) begin
         mem[bank][addr] <= wdata;
      end
   end

   assign rdata = mem[bank][addr];

   // Bit column 'bit_idx' of every row, for both banks at once
   always_comb begin
      slice_l = '0;
      slice_r = '0;
      for (int r = 0; r < CELL_QUANT; r++) begin
         slice_l[r] = mem[0][r][bit_idx];
         slice_r[r] = mem[1][r][bit_idx];
      end
   end

endmodule

// File: rtl/ap_s.sv
// Associative processor: three two-bank CAMs (A, B, C), a host word port in
// memory mode, and a row-parallel bit-serial ALU driven by a small FSM in
// compute mode. MULT keeps shadow copies of its operand bit columns so that a
// destination aliasing an operand still sees the original operand values.
module ap_s
   import ap_pkg::*;
#(
   parameter  int WORD_SIZE  = 8,
   parameter  int CELL_QUANT = 512,
   localparam int ADDR_W     = $clog2(CELL_QUANT)
) (
   input  logic                 CLK100MHZ,
   input  logic                 rst,
   input  logic [2:0]           clr,
   input  logic [ADDR_W-1:0]    addr_in,
   input  logic [WORD_SIZE-1:0] data_in,
   input  logic                 ap_mode,
   input  logic                 op_direction,
   input  logic                 op_target,
   input  logic [2:0]           cmd,
   input  logic [1:0]           sel_col,
   input  logic                 sel_internal_col,
   input  logic                 write_en,
   input  logic                 read_en,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 ap_state_irq
);

   localparam int BIT_W = $clog2(WORD_SIZE);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_SIZE - 1);

   state_t               state;
   logic [2:0]           cmd_q;
   logic                 dir_q, tgt_q, bank_q, setup;
   logic [1:0]           sel_q;
   logic [WORD_SIZE-1:0] val_q;
   logic [BIT_W-1:0]     p, j, diff;
   logic [CELL_QUANT-1:0] carry, cout, res, x_s, y_s, d_s, yy, xs, yj, a_s, b_s, c_in;
   logic [CELL_QUANT-1:0] xsh [WORD_SIZE];
   logic [CELL_QUANT-1:0] ysh [WORD_SIZE];
   logic [CELL_QUANT-1:0] sl [4];
   logic [CELL_QUANT-1:0] sr [4];
   logic [WORD_SIZE-1:0]  rd [4];
   logic [2:0] mem_we, clr_en, fill_en, bs_we;
   logic [1:0] dest;
   logic       idle, mem_mode, in_run, nop_op, single_cycle, bit_step, addr_ok, bank_sel;

   assign sl[3] = '0;
   assign sr[3] = '0;
   assign rd[3] = '0;

   for (genvar k = 0; k < 3; k++) begin : g_cam
      ap_cam #(.WORD_SIZE(WORD_SIZE), .CELL_QUANT(CELL_QUANT)) u_cam (
         .clk(CLK100MHZ), .rst(rst), .bank(bank_sel),
         .we(mem_we[k]), .addr(addr_in), .wdata(data_in), .rdata(rd[k]),
         .clr_en(clr_en[k]), .fill_en(fill_en[k]), .fill_value(val_q),
         .bit_idx(p), .slice_l(sl[k]), .slice_r(sr[k]),
         .bs_we(bs_we[k]), .bs_data(res)
      );
   end

   // Operation decode and per-CAM strobes
   always_comb begin
      idle         = (state == ST_IDLE);
      in_run       = (state == ST_RUN);
      mem_mode     = idle && !ap_mode;
      addr_ok      = (32'(addr_in) < CELL_QUANT);
      bank_sel     = idle ? sel_internal_col : bank_q;
      nop_op       = (sel_q == CAM_NONE) ||
                     (cmd_q != CMD_SET && sel_q == CAM_C && tgt_q == TGT_SRC);
      single_cycle = nop_op || (cmd_q == CMD_SET);
      bit_step     = in_run && !single_cycle && !setup;
      dest         = (tgt_q == TGT_SRC || cmd_q == CMD_SET) ? sel_q : CAM_C;
      for (int k = 0; k < 3; k++) begin
         mem_we[k]  = mem_mode && write_en && addr_ok && (sel_col == 2'(k));
         clr_en[k]  = idle && clr[k];
         fill_en[k] = in_run && (cmd_q == CMD_SET) && (sel_q == 2'(k));
         bs_we[k]   = bit_step && (dest == 2'(k));
      end
   end

   // Operand/destination bit columns for the current bit position
   always_comb begin
      if (dir_q == DIR_HORZ) begin
         x_s = sl[sel_q];
         y_s = sr[sel_q];
      end else begin
         x_s = bank_q ? sr[CAM_A] : sl[CAM_A];
         y_s = bank_q ? sr[CAM_B] : sl[CAM_B];
      end
      d_s = bank_q ? sr[dest] : sl[dest];
   end

   // Row-parallel bit-serial ALU; carry restarts at bit 0 of every pass
   always_comb begin
      c_in = (p == '0) ? ((cmd_q == CMD_SUB) ? '1 : '0) : carry;
      diff = p - j;
      res  = '0;
      cout = carry;
      yy   = (cmd_q == CMD_SUB) ? ~y_s : y_s;
      xs   = (j == '0) ? x_s : ((p >= j) ? xsh[diff] : '0);
      yj   = (j == '0 && p == '0) ? y_s : ysh[j];
      a_s  = (j == '0) ? '0 : d_s;
      b_s  = xs & yj;
      case (cmd_q)
         CMD_OR:  res = x_s | y_s;
         CMD_XOR: res = x_s ^ y_s;
         CMD_AND: res = x_s & y_s;
         CMD_NOT: res = ~x_s;
         CMD_ADD, CMD_SUB: begin
            res  = x_s ^ yy ^ c_in;
            cout = (x_s & yy) | (c_in & (x_s ^ yy));
         end
         CMD_MULT: begin
            res  = a_s ^ b_s ^ c_in;
            cout = (a_s & b_s) | (c_in & (a_s ^ b_s));
         end
         default: res = '0;
      endcase
   end

   // FSM: latch the command, step bit/pass counters, signal completion
   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cmd_q <= '0; dir_q <= 1'b0; tgt_q <= 1'b0; bank_q <= 1'b0;
         sel_q <= '0; val_q <= '0; p <= '0; j <= '0; setup <= 1'b0;
         ap_state_irq <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               ap_state_irq <= 1'b0;
               if (ap_mode) begin
                  cmd_q <= cmd; dir_q <= op_direction; tgt_q <= op_target;
                  sel_q <= sel_col; bank_q <= sel_internal_col; val_q <= data_in;
                  p <= '0; j <= '0;
                  setup <= (cmd == CMD_MULT);
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (single_cycle) begin
                  state <= ST_DONE;
               end else if (setup) begin
                  setup <= 1'b0;
               end else if (p == LAST_BIT) begin
                  p <= '0;
                  if (cmd_q != CMD_MULT || j == LAST_BIT) state <= ST_DONE;
                  else j <= j + 1'b1;
               end else begin
                  p <= p + 1'b1;
               end
            end
            ST_DONE: begin
               ap_state_irq <= 1'b1;
               if (!ap_mode) begin
                  ap_state_irq <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Per-row carry, plus operand shadows captured during the first MULT pass
   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         carry <= '0;
         for (int i = 0; i < WORD_SIZE; i++) begin
            xsh[i] <= '0;
            ysh[i] <= '0;
         end
      end else if (bit_step) begin
         carry <= cout;
         if (cmd_q == CMD_MULT && j == '0) begin
            xsh[p] <= x_s;
            ysh[p] <= y_s;
         end
      end
   end

   // Registered host read; a same-cycle write takes precedence
   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) data_out <= '0;
      else if (mem_mode && read_en && !write_en) data_out <= addr_ok ? rd[sel_col] : '0;
   end

endmodule

// File: tb/tb_ap_s.sv
module tb_ap_s;
   import ap_pkg::*;

   localparam int WS = 8;
   localparam int CQ = 512;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2:0]    clr = '0;
   logic [AW-1:0] addr_in = '0;
   logic [WS-1:0] data_in = '0;
   logic          ap_mode = 1'b0, op_direction = 1'b0, op_target = 1'b0;
   logic [2:0]    cmd = '0;
   logic [1:0]    sel_col = '0;
   logic          sel_internal_col = 1'b0, write_en = 1'b0, read_en = 1'b0;
   logic [WS-1:0] data_out;
   logic          ap_state_irq;

   int n_checks = 0;
   int n_fail   = 0;

   ap_s #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
      .CLK100MHZ(clk), .rst(rst), .clr(clr), .addr_in(addr_in), .data_in(data_in),
      .ap_mode(ap_mode), .op_direction(op_direction), .op_target(op_target),
      .cmd(cmd), .sel_col(sel_col), .sel_internal_col(sel_internal_col),
      .write_en(write_en), .read_en(read_en), .data_out(data_out),
      .ap_state_irq(ap_state_irq)
   );

   // clock
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] add;
      logic [7:0] sub;
      logic [7:0] mul;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic do_write(input logic [1:0] cam, input logic bank, input int addr, input logic [7:0] val);
      @(negedge clk);
      sel_col = cam; sel_internal_col = bank; addr_in = AW'(addr); data_in = val; write_en = 1'b1;
      @(negedge clk);
      write_en = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] cam, input logic bank, input int addr, output logic [7:0] val);
      @(negedge clk);
      sel_col = cam; sel_internal_col = bank; addr_in = AW'(addr); read_en = 1'b1;
      @(posedge clk);
      #1 val = data_out;
      read_en = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [1:0] cam, input logic bank,
                             input int addr, input logic [7:0] exp);
      logic [7:0] v;
      do_read(cam, bank, addr, v);
      check(name, {24'd0, v}, {24'd0, exp});
   endtask

   // Start an operation, count cycles from the sampling edge to irq, then release
   task automatic run_op(input string name, input logic [2:0] c, input logic d, input logic t,
                         input logic [1:0] s, input logic b, input logic [7:0] v, input int lat);
      int cnt;
      @(negedge clk);
      cmd = c; op_direction = d; op_target = t; sel_col = s; sel_internal_col = b;
      data_in = v; ap_mode = 1'b1;
      @(posedge clk);
      cnt = 0;
      while (cnt < 200) begin
         @(posedge clk);
         #1 cnt++;
         if (ap_state_irq) break;
      end
      check({name, "_latency"}, cnt, lat + 1);
      @(negedge clk);
      ap_mode = 1'b0;
      @(posedge clk);
      #1 check({name, "_irq_clear"}, {31'd0, ap_state_irq}, 0);
   endtask

   initial begin
      logic [7:0] v;
      tbl[0]  = '{8'd3,   8'd0,  8'd3,   8'd3,   8'd0};
      tbl[1]  = '{8'd7,   8'd1,  8'd8,   8'd6,   8'd7};
      tbl[2]  = '{8'd0,   8'd2,  8'd2,   8'd254, 8'd0};
      tbl[3]  = '{8'd255, 8'd3,  8'd2,   8'd252, 8'd253};
      tbl[4]  = '{8'd100, 8'd4,  8'd104, 8'd96,  8'd144};
      tbl[5]  = '{8'd128, 8'd5,  8'd133, 8'd123, 8'd128};
      tbl[6]  = '{8'd200, 8'd6,  8'd206, 8'd194, 8'd176};
      tbl[7]  = '{8'd1,   8'd7,  8'd8,   8'd250, 8'd7};
      tbl[8]  = '{8'd50,  8'd8,  8'd58,  8'd42,  8'd144};
      tbl[9]  = '{8'd77,  8'd9,  8'd86,  8'd68,  8'd181};
      tbl[10] = '{8'd5,   8'd9,  8'd14,  8'd252, 8'd45};
      tbl[11] = '{8'd13,  8'd11, 8'd24,  8'd2,   8'd143};
      tbl[12] = '{8'd15,  8'd15, 8'd30,  8'd0,   8'd225};

      // reset state
      #1;
      check("reset_data_out", {24'd0, data_out}, 0);
      check("reset_irq", {31'd0, ap_state_irq}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // memory mode basics
      do_write(CAM_A, LEFT, 5, 8'hAB);
      read_check("mem_a0_r5", CAM_A, LEFT, 5, 8'hAB);
      read_check("mem_b0_r5", CAM_B, LEFT, 5, 8'h00);
      do_write(CAM_NONE, LEFT, 6, 8'h11);
      read_check("mem_none_read", CAM_NONE, LEFT, 6, 8'h00);

      // write has priority over read: data_out keeps the last read value
      read_check("prio_pre", CAM_A, LEFT, 5, 8'hAB);
      @(negedge clk);
      sel_col = CAM_A; sel_internal_col = LEFT; addr_in = AW'(40); data_in = 8'h77;
      write_en = 1'b1; read_en = 1'b1;
      @(posedge clk);
      #1 check("prio_hold", {24'd0, data_out}, 32'hAB);
      write_en = 1'b0; read_en = 1'b0;
      read_check("prio_written", CAM_A, LEFT, 40, 8'h77);

      // operand load
      for (int i = 0; i < 13; i++) begin
         do_write(CAM_A, LEFT, i, tbl[i].a);
         do_write(CAM_B, LEFT, i, tbl[i].b);
      end

      run_op("add", CMD_ADD, DIR_VERT, TGT_C, CAM_A, LEFT, 8'd0, WS);
      for (int i = 0; i < 13; i++) read_check($sformatf("add_row%0d", i), CAM_C, LEFT, i, tbl[i].add);

      run_op("sub", CMD_SUB, DIR_VERT, TGT_C, CAM_A, LEFT, 8'd0, WS);
      for (int i = 0; i < 13; i++) read_check($sformatf("sub_row%0d", i), CAM_C, LEFT, i, tbl[i].sub);
      read_check("sub_row100", CAM_C, LEFT, 100, 8'd0);

      run_op("mult", CMD_MULT, DIR_VERT, TGT_C, CAM_A, LEFT, 8'd0, 1 + WS * WS);
      for (int i = 0; i < 13; i++) read_check($sformatf("mult_row%0d", i), CAM_C, LEFT, i, tbl[i].mul);

      // result written back to A; C untouched
      run_op("add_src", CMD_ADD, DIR_VERT, TGT_SRC, CAM_A, LEFT, 8'd0, WS);
      read_check("add_src_a3", CAM_A, LEFT, 3, tbl[3].add);
      read_check("add_src_a11", CAM_A, LEFT, 11, tbl[11].add);
      read_check("add_src_c12", CAM_C, LEFT, 12, tbl[12].mul);

      // no-op compute
      run_op("nop", CMD_ADD, DIR_VERT, TGT_C, CAM_NONE, LEFT, 8'd0, 1);
      read_check("nop_c12", CAM_C, LEFT, 12, tbl[12].mul);

      // horizontal XOR over B's two banks
      do_write(CAM_B, LEFT, 20, 8'hF0);
      do_write(CAM_B, RIGHT, 20, 8'h3C);
      run_op("hxor", CMD_XOR, DIR_HORZ, TGT_C, CAM_B, LEFT, 8'd0, WS);
      read_check("hxor_r20", CAM_C, LEFT, 20, 8'hCC);
      read_check("hxor_r1", CAM_C, LEFT, 1, 8'h01);

      // SET_VALUE on C right bank
      run_op("set", CMD_SET, DIR_VERT, TGT_C, CAM_C, RIGHT, 8'd10, 1);
      read_check("set_r0", CAM_C, RIGHT, 0, 8'd10);
      read_check("set_r300", CAM_C, RIGHT, 300, 8'd10);
      read_check("set_r511", CAM_C, RIGHT, 511, 8'd10);
      read_check("set_c0_kept", CAM_C, LEFT, 20, 8'hCC);

      // bank clear of B right
      do_write(CAM_B, RIGHT, 7, 8'd55);
      @(negedge clk);
      clr = 3'b010; sel_internal_col = RIGHT;
      @(negedge clk);
      clr = 3'b000;
      read_check("clr_b1_r7", CAM_B, RIGHT, 7, 8'd0);
      read_check("clr_b1_r20", CAM_B, RIGHT, 20, 8'd0);
      read_check("clr_b0_r7", CAM_B, LEFT, 7, tbl[7].b);

      // reset in the middle of a MULT
      @(negedge clk);
      cmd = CMD_MULT; op_direction = DIR_VERT; op_target = TGT_C; sel_col = CAM_A;
      sel_internal_col = LEFT; ap_mode = 1'b1;
      repeat (20) @(posedge clk);
      #2 rst = 1'b0;
      #1 check("midrst_irq", {31'd0, ap_state_irq}, 0);
      check("midrst_data_out", {24'd0, data_out}, 0);
      @(negedge clk);
      ap_mode = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      read_check("midrst_a1", CAM_A, LEFT, 1, 8'd0);
      read_check("midrst_c1_r0", CAM_C, RIGHT, 0, 8'd0);
      do_write(CAM_A, LEFT, 3, 8'h5A);
      read_check("midrst_idle_rw", CAM_A, LEFT, 3, 8'h5A);
      repeat (10) @(posedge clk);
      #1 check("midrst_no_irq", {31'd0, ap_state_irq}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ap_s.md
Name: ap_s

Overview:
- Associative processor (AP) block: three word-addressable CAM arrays (A, B, C), each holding two internal columns ("banks") of CELL_QUANT words.
- Memory mode: a host loads and reads words one at a time.
- Compute mode: the block applies a command to every row in parallel, bit-serially from LSB to MSB, then raises an interrupt.
- Sits between the host register interface (ap_if bundle) and on-chip storage.

Parameters:
- WORD_SIZE, 8, bits per word.
- CELL_QUANT, 512, rows per bank.
- ADDR_W, clog2(CELL_QUANT) (9), address width; derived, not overridable.

Ports:
- CLK100MHZ  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  3  synchronous bank clear, one-hot {C,B,A}; clears bank sel_internal_col of each flagged CAM; honoured only in IDLE.
- addr_in  in  ADDR_W  row address.
- data_in  in  WORD_SIZE  write data / SET_VALUE operand.
- ap_mode  in  1  0 = memory mode, 1 = compute request.
- op_direction  in  1  0 = vertical, 1 = horizontal.
- op_target  in  1  0 = result to CAM C, 1 = result written back to source CAM.
- cmd  in  3  0 OR, 1 XOR, 2 AND, 3 NOT, 4 ADD, 5 SUB, 6 MULT, 7 SET_VALUE.
- sel_col  in  2  0 CAM A, 1 CAM B, 2 CAM C, 3 none.
- sel_internal_col  in  1  bank select, 0 LEFT, 1 RIGHT.
- write_en  in  1  memory write strobe.
- read_en  in  1  memory read strobe.
- data_out  out  WORD_SIZE  registered read data.
- ap_state_irq  out  1  completion flag.

Behaviour:
- Reset (rst=0, asynchronous): all storage, data_out, ap_state_irq and carries clear to 0; FSM to IDLE. Reset mid-operation aborts with no completion flag.
- Memory mode (IDLE, ap_mode=0):
  - write_en=1: mem[sel_col][sel_internal_col][addr_in] <= data_in at the clock edge.
  - read_en=1: data_out <= the same word one cycle later.
  - write_en has priority over read_en on the same cycle.
  - sel_col=3: writes ignored, reads return 0.
  - addr_in >= CELL_QUANT: writes ignored, reads return 0.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
  - IDLE -> RUN: ap_mode=1 sampled; cmd, op_direction, op_target, sel_col, sel_internal_col and data_in are latched.
  - RUN -> DONE: final step completes.
  - DONE: ap_state_irq=1, held until ap_mode=0, then back to IDLE. ap_mode must drop before a new operation starts.
- Writes, reads and clr are ignored outside IDLE.
- Operand and destination selection:
  - Vertical: X = A[b], Y = B[b], with b = sel_internal_col.
  - Horizontal: X = S[0], Y = S[1], with S = sel_col CAM (A or B).
  - Destination with op_target=0: C[b].
  - Destination with op_target=1: the CAM given by sel_col, bank b.
- Bit-serial execution: one bit position per cycle, all rows in parallel.
  - OR/XOR/AND: WORD_SIZE cycles, bitwise.
  - NOT: ~X, WORD_SIZE cycles.
  - ADD/SUB: per-row carry register; initial carry 0 for ADD, 1 for SUB (Y inverted). WORD_SIZE cycles. Result is modulo 2^WORD_SIZE; final carry discarded.
  - MULT: destination cleared in the first cycle, then WORD_SIZE shift-add passes of WORD_SIZE cycles each. Pass j adds (X<<j) where Y[j]=1. Result = low WORD_SIZE bits of X*Y. Latency 1+WORD_SIZE^2 cycles.
  - SET_VALUE: every row of bank sel_col/sel_internal_col <= latched data_in in 1 cycle. op_direction and op_target are ignored.
- Total latency: ap_state_irq rises exactly latency+1 cycles after ap_mode is sampled.
- Aliasing: when the destination equals an operand, each bit is read before it is written in the same cycle, so the result is as if all operands were read beforehand.
- sel_col=3 or sel_col=2 with op_target=1 in compute: no storage change; DONE after 1 cycle.

Decomposition:
- Package ap_pkg: cmd encodings, CAM select constants (CAM_A/B/C), LEFT/RIGHT, direction constants, FSM state enum.
- One sub-module ap_cam: one CAM with two banks. Provides:
  - word read/write port;
  - bank clear;
  - row-parallel bit-slice read of both banks;
  - row-parallel bit-slice write.
- ap_s instantiates three ap_cam plus a row-parallel bit-serial ALU and the FSM.

Test Plan:
- Reset, then write A[0] row 5 = 8'hAB; read_en -> data_out = 8'hAB one cycle later. Read B[0] row 5 -> 8'h00.
- Load A[0] rows 0..9 = 3,7,0,255,...; B[0] rows 0..9 = 0,1,2,...; ADD, vertical, op_target=0 -> C[0][i] = (A+B) mod 256 (row 3: 255+3 = 2). irq rises at cycle WORD_SIZE+1.
- SUB with A=5, B=9 -> 252. MULT with A=13, B=11 -> 143 (low byte); MULT with A=15, B=15 -> 225. irq only after 1+64 cycles.
- ADD with op_target=1, sel_col=A -> A[0] rows become A+B; C is unchanged.
- Horizontal XOR, sel_col=B, with B[0]=8'hF0, B[1]=8'h3C -> C[0] = 8'hCC. SET_VALUE data_in=10 on C[1] -> all rows read 10.
- Assert rst low mid-MULT -> irq=0, all storage zero, FSM IDLE. clr=3'b010 with sel_internal_col=1 -> B[1] zeroed, B[0] intact.
